serial_tx_scheduler: RTL and testbench
======================================

SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

Interface
REQ-001 The block SHALL have parameter MSG_W, default 4, giving the message width in bits.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 7, giving the maximum number of cycles to wait for TX_BUSY after a launch.
REQ-003 CLK  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 RSTn  in  1  asynchronous, active-low reset.
REQ-005 EN  in  1  enables new grants; a transfer already in progress SHALL run to completion when EN is low.
REQ-006 REQ  in  4  per-requester level request, one bit per requester 0..3.
REQ-007 MSG  in  4*MSG_W  packed messages; requester i occupies bits [i*MSG_W +: MSG_W].
REQ-008 SB  in  4  stand-by gap, in cycles, inserted after each transfer.
REQ-009 TX_BUSY  in  1  transmitter busy, driven by the serial transmitter.
REQ-010 TX_INIT  out  1  one-cycle launch pulse to the transmitter.
REQ-011 TX_MSG  out  MSG_W  message presented to the transmitter.
REQ-012 GNT  out  4  one-hot, one-cycle grant pulse.
REQ-013 ACTIVE  out  2  index of the current or most recent requester.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 ERR  out  1  sticky acknowledge-timeout flag.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LAUNCH, WAIT_ACK, SEND and GAP.
REQ-017 In IDLE with EN=1 and REQ!=0, the block SHALL select a winner, latch its MSG slice and index, and move to LAUNCH on the next edge.
REQ-018 In IDLE with EN=0 or REQ=0, the block SHALL remain in IDLE.
REQ-019 Latency: REQ sampled at edge k SHALL produce GNT[w]=1 and TX_INIT=1 throughout cycle k+1 (LAUNCH), both registered.
REQ-020 LAUNCH SHALL last exactly one cycle and then move to WAIT_ACK.
REQ-021 Arbitration SHALL be round-robin: the search starts at last_grant+1 modulo 4.
REQ-022 The round-robin pointer SHALL update only when a grant is issued.
REQ-023 WAIT_ACK SHALL move to SEND on the first cycle in which TX_BUSY=1.
REQ-024 If TX_BUSY stays 0 for ACK_TIMEOUT cycles in WAIT_ACK, the block SHALL set ERR=1 and move to GAP.
REQ-025 SEND SHALL move to GAP on the first cycle in which TX_BUSY=0.
REQ-026 GAP SHALL load SB on entry and stay for exactly SB cycles before moving to IDLE.
REQ-027 When SB=0, GAP SHALL last exactly 1 cycle.
REQ-028 SB changes during GAP SHALL have no effect on the current gap.
REQ-029 TX_MSG and ACTIVE SHALL hold the latched values from LAUNCH through IDLE until the next grant.
REQ-030 MSG changes after the grant SHALL have no effect on TX_MSG.
REQ-031 A requester that deasserts REQ after its grant SHALL NOT abort the transfer.
REQ-032 A requester that holds REQ high SHALL be re-granted only after every other pending requester has been served.
REQ-033 Simultaneous requests SHALL be resolved in a single cycle, with no lost or duplicated grants.
REQ-034 GNT SHALL never have more than one bit set.
REQ-035 TX_INIT SHALL never be high outside LAUNCH.

Reset
REQ-036 RSTn=0 SHALL immediately force: state IDLE, TX_INIT=0, GNT=0, TX_MSG=0, ACTIVE=0, BUSY=0, ERR=0, gap and timeout counters 0, and the pointer set so that requester 0 is searched first.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer with no further TX_INIT pulse.
REQ-038 ERR SHALL be cleared only by reset.

Configuration
REQ-039 With macro SERIAL_ALARM_PRIORITY_EN defined, REQ[0] SHALL win in IDLE whenever asserted, and requesters 1..3 SHALL share round-robin among themselves.
REQ-040 Without SERIAL_ALARM_PRIORITY_EN, arbitration SHALL be pure round-robin over 0..3.

Verification
REQ-041 After reset, REQ=4'b0001, MSG slice0=4'hA, SB=3, TX_BUSY high 2 cycles after launch for 5 cycles -> GNT=4'b0001 and TX_INIT for 1 cycle, TX_MSG=4'hA, BUSY high until 3 GAP cycles end, ERR=0.
REQ-042 REQ=4'b1111 held, 4 transfers, macro off -> grant order 0,1,2,3, then 0 again.
REQ-043 REQ=4'b1111 held, macro on -> every grant goes to requester 0.
REQ-044 Macro on, REQ=4'b1110 -> grant order 1,2,3.
REQ-045 TX_BUSY held 0 after launch -> ERR=1 on the 7th WAIT_ACK cycle, GAP entered, ERR stays 1 across later good transfers.
REQ-046 RSTn pulsed low during SEND -> all outputs return to reset values within the same cycle, and no TX_INIT pulse appears until a new request.
REQ-047 EN=0 with REQ=4'b0010 -> no grant; EN raised -> GNT=4'b0010 one cycle later.
REQ-048 SB=0 -> exactly 1 GAP cycle between TX_BUSY falling and the next TX_INIT.

Source files
------------

// File: rtl/serial_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_tx_scheduler
//  Purpose  : Round-robin scheduler for four requesters sharing one serial
//             transmitter. Each transfer runs: launch pulse, wait for the
//             transmitter to report busy (with timeout), follow it through
//             the send, then hold off for a programmable stand-by gap.
//  Options  : SERIAL_ALARM_PRIORITY_EN - requester 0 always wins when it
//             requests; requesters 1..3 rotate among themselves.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx_scheduler #(
   parameter int MSG_W       = 4,
   parameter int ACK_TIMEOUT = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [3:0]         req,
   input  logic [4*MSG_W-1:0] msg,
   input  logic [3:0]         sb,
   input  logic               tx_busy,
   output logic               tx_init,
   output logic [MSG_W-1:0]   tx_msg,
   output logic [3:0]         gnt,
   output logic [1:0]         active,
   output logic               busy,
   output logic               err
);

   localparam int                c_TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LAUNCH   = 3'd1,
      S_WAIT_ACK = 3'd2,
      S_SEND     = 3'd3,
      S_GAP      = 3'd4
   } state_t;

   state_t              r_state;
   logic [1:0]          r_last;
   logic [c_TO_W-1:0]   r_to;
   logic [3:0]          r_gap;
   logic                r_tx_init;
   logic [MSG_W-1:0]    r_tx_msg;
   logic [3:0]          r_gnt;
   logic [1:0]          r_active;
   logic                r_busy;
   logic                r_err;

   logic                w_found;
   logic [1:0]          w_win;
   logic [3:0]          w_req_m;
   logic [3:0]          w_gap_load;

   // A zero stand-by setting still costs one gap cycle
   assign w_gap_load = (sb == 4'd0) ? 4'd1 : sb;

   // Winner search: first requester found walking forward from the last grant
   always_comb begin
      logic [1:0] idx;
      w_found = 1'b0;
      w_win   = 2'd0;
      w_req_m = req;
      idx     = 2'd0;
`ifdef SERIAL_ALARM_PRIORITY_EN
      if (req[0]) begin
         w_found = 1'b1;
         w_win   = 2'd0;
      end
      w_req_m = req & 4'b1110;
`endif
      for (int i = 1; i <= 4; i++) begin
         idx = r_last + 2'(i);
         if (!w_found && w_req_m[idx]) begin
            w_found = 1'b1;
            w_win   = idx;
         end
      end
   end

   // Transfer sequencer with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_last    <= 2'd3;
         r_to      <= '0;
         r_gap     <= 4'd0;
         r_tx_init <= 1'b0;
         r_tx_msg  <= '0;
         r_gnt     <= 4'd0;
         r_active  <= 2'd0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (en && w_found) begin
                  r_state   <= S_LAUNCH;
                  r_tx_init <= 1'b1;
                  r_gnt     <= 4'b0001 << w_win;
                  r_tx_msg  <= msg[int'(w_win)*MSG_W +: MSG_W];
                  r_active  <= w_win;
                  r_busy    <= 1'b1;
`ifdef SERIAL_ALARM_PRIORITY_EN
                  if (w_win != 2'd0) begin
                     r_last <= w_win;
                  end
`else
                  r_last    <= w_win;
`endif
               end
            end
            S_LAUNCH: begin
               r_tx_init <= 1'b0;
               r_gnt     <= 4'd0;
               r_to      <= '0;
               r_state   <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (tx_busy) begin
                  r_state <= S_SEND;
               end else if (r_to == c_TO_LAST) begin
                  r_err   <= 1'b1;
                  r_gap   <= w_gap_load;
                  r_state <= S_GAP;
               end else begin
                  r_to <= r_to + 1'b1;
               end
            end
            S_SEND: begin
               if (!tx_busy) begin
                  r_gap   <= w_gap_load;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_gap <= 4'd1) begin
                  r_gap   <= 4'd0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_gap <= r_gap - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_init = r_tx_init;
   assign tx_msg  = r_tx_msg;
   assign gnt     = r_gnt;
   assign active  = r_active;
   assign busy    = r_busy;
   assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_scheduler
//  Purpose  : Self-checking bench for serial_tx_scheduler. Each transfer's
//             timeline is predicted from its parameters (ack delay, busy
//             length, stand-by gap, timeout) and the winner from a
//             round-robin pointer model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_scheduler;

   localparam int MSG_W = 4;
   localparam int TO    = 7;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic [3:0]         req;
   logic [4*MSG_W-1:0] msg;
   logic [3:0]         sb;
   logic               tx_busy;
   logic               tx_init;
   logic [MSG_W-1:0]   tx_msg;
   logic [3:0]         gnt;
   logic [1:0]         active;
   logic               busy;
   logic               err;

   int n_checks = 0;
   int n_fail   = 0;
   int m_last;
   bit m_err;

   serial_tx_scheduler #(.MSG_W(MSG_W), .ACK_TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .msg     (msg),
      .sb      (sb),
      .tx_busy (tx_busy),
      .tx_init (tx_init),
      .tx_msg  (tx_msg),
      .gnt     (gnt),
      .active  (active),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Round-robin rule: first requester after the previous winner
   function automatic int exp_winner(input logic [3:0] r);
      logic [3:0] rr;
      rr = r;
`ifdef SERIAL_ALARM_PRIORITY_EN
      if (rr[0]) return 0;
      rr[0] = 1'b0;
`endif
      for (int i = 1; i <= 4; i++) begin
         if (rr[(m_last + i) % 4]) return (m_last + i) % 4;
      end
      return -1;
   endfunction

   // One transfer starting at an IDLE negedge; ends at the next IDLE negedge.
   // d: WAIT_ACK cycles before tx_busy rises, l: tx_busy high cycles,
   // tmo: transmitter never answers.
   task automatic txn(input logic [3:0] r, input logic [15:0] m, input logic [3:0] s,
                      input int d, input int l, input bit tmo);
      int         w;
      int         g;
      int         t;
      logic [3:0] exp_msg;
      w   = exp_winner(r);
      en  = 1'b1;
      req = r;
      msg = m;
      sb  = s;
      tx_busy = 1'b0;
      exp_msg = m[w*4 +: 4];
      g = (s == 4'd0) ? 1 : int'(s);
      t = tmo ? (TO + 1 + g) : (d + 2 + l + g);
      for (int c = 0; c <= t; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("grant", 32'(gnt), 32'(4'b0001 << w));
            check("launch", 32'(tx_init), 32'd1);
            check("msg_latch", 32'(tx_msg), 32'(exp_msg));
            check("active", 32'(active), 32'(w));
`ifdef SERIAL_ALARM_PRIORITY_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
            msg = 16'($urandom);
            req = 4'($urandom);
            en  = 1'($urandom);
         end else begin
            check("busy", 32'(busy), 32'(c < t));
            check("no_pulse", 32'({tx_init, gnt}), 32'd0);
            check("err", 32'(err), 32'(m_err || (tmo && c >= TO + 1)));
         end
         tx_busy = !tmo && (c >= d + 1) && (c <= d + l);
         if (c == t - g) sb = 4'($urandom);
      end
      if (tmo) m_err = 1'b1;
      check("msg_hold", 32'(tx_msg), 32'(exp_msg));
      check("active_hold", 32'(active), 32'(w));
   endtask

   task automatic check_reset_outputs;
      check("rst_init", 32'(tx_init), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_msg", 32'(tx_msg), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
   endtask

   initial begin
      int w;
      rst_n = 1'b0; en = 1'b0; req = 4'd0; msg = '0; sb = 4'd0; tx_busy = 1'b0;
      m_last = 3;
      m_err  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      // Single request, ack two cycles after launch, 5 busy cycles, 3-cycle gap
      txn(4'b0001, 16'h000A, 4'd3, 1, 5, 1'b0);

      // All requesting: rotation then wrap
      for (int k = 0; k < 5; k++) txn(4'b1111, 16'($urandom), 4'd2, 0, 2, 1'b0);

      // Enable low blocks new grants
      en = 1'b0; req = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("en_low_gnt", 32'({busy, gnt}), 32'd0);
      end
      txn(4'b0010, 16'($urandom), 4'd1, 2, 3, 1'b0);

      // Acknowledge timeout, then ERR stays set over a good transfer
      txn(4'b1000, 16'($urandom), 4'd1, 0, 1, 1'b1);
      txn(4'b0101, 16'($urandom), 4'd2, 3, 2, 1'b0);

      // Zero stand-by gap
      txn(4'b0100, 16'($urandom), 4'd0, 2, 1, 1'b0);

      // Randomized traffic
      for (int k = 0; k < 30; k++) begin
         logic [3:0] r;
         r = 4'($urandom_range(1, 15));
         txn(r, 16'($urandom), 4'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
             int'($urandom_range(1, 4)), ($urandom_range(0, 4) == 0));
      end

      // Reset in the middle of SEND
      w = exp_winner(4'b0100);
      en = 1'b1; req = 4'b0100; sb = 4'd2; tx_busy = 1'b0;
      @(negedge clk);
      check("mid_grant", 32'(gnt), 32'(4'b0001 << w));
      tx_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("mid_send_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1; req = 4'd0; tx_busy = 1'b0;
      m_last = 3;
      m_err  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_quiet", 32'({busy, tx_init}), 32'd0);
      end
      // Pointer restarts at requester 0 after reset
      txn(4'b0110, 16'h4321, 4'd1, 0, 1, 1'b0);
      req = 4'd0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
